cpu_control_pipeline: RTL and testbench

//  Control end of the pipelined LEGv8 datapath. Decodes the fetched instruction in ID.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/cpu_control_pipeline_if.sv | 54 +++++
 rtl/cpu_control_decode.sv | 86 ++++++++
 rtl/cpu_control_pipeline.sv | 113 +++++++++++
 tb/tb_cpu_control_pipeline.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the LEGv8 pipeline control unit: opcode table, ALU and
// forwarding encodings, and the control bundle that rides along each stage.
package cpu_pkg;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_AND   = 11'b10001010000;
  localparam logic [10:0] OP_EOR   = 11'b11001010000;
  localparam logic [10:0] OP_LSR   = 11'b11010011010;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  // Only signed less-than is supported for B.cond.
  localparam logic [3:0]  COND_LT  = 4'hB;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b010,
    ALU_SUB   = 3'b011,
    ALU_AND   = 3'b100,
    ALU_OR    = 3'b101,
    ALU_XOR   = 3'b110
  } alu_op_e;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_EX  = 2'b10;

  // Full bundle decoded in ID and held in the EX stage register.
  typedef struct packed {
    logic       reg_wren;
    logic       mem_wren;
    logic       mem2reg;
    alu_op_e    alu_op;
    logic       shift2reg;
    logic       set_flags;
    logic [5:0] shamt;
  } ctrl_t;

  // Subset that survives past EX.
  typedef struct packed {
    logic reg_wren;
    logic mem_wren;
    logic mem2reg;
  } mem_ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

  // The younger producer (EX) holds the newer value, so it wins over MEM.
  function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit);
    if (ex_hit)       return FWD_EX;
    else if (mem_hit) return FWD_MEM;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/cpu_control_pipeline_if.sv
// Control <-> datapath bundle. The control unit is the master; the datapath
// supplies the fetched instruction and flags and consumes everything else.
interface cpu_control_pipeline_if #(
  parameter int NUM_REGS = 32
);
  localparam int AW = $clog2(NUM_REGS);

  logic [31:0]   instruction;
  logic          alu_zero;
  logic          cbz_zero;
  logic          negative;
  logic          overflow;

  logic          Reg2Loc;
  logic          ALU_Src;
  logic          Imm2ALU;
  logic          UncondBr;
  logic          BrTaken;
  logic          Shift2Reg;
  logic          SetFlags;
  logic          MemWren;
  logic          Mem2Reg;
  logic          RegWren;
  logic [2:0]    ALU_Op;
  logic [25:0]   Imm26;
  logic [18:0]   Imm19;
  logic [11:0]   Imm12;
  logic [8:0]    Imm9;
  logic [5:0]    Shamt;
  logic [AW-1:0] Rn;
  logic [AW-1:0] Rm;
  logic [AW-1:0] Rd;
  logic [AW-1:0] Rd2;
  logic [1:0]    forward_Da;
  logic [1:0]    forward_Db;
  logic          load_use;

  modport master (
    input  instruction, alu_zero, cbz_zero, negative, overflow,
    output Reg2Loc, ALU_Src, Imm2ALU, UncondBr, BrTaken,
    output Shift2Reg, SetFlags, MemWren, Mem2Reg, RegWren, ALU_Op,
    output Imm26, Imm19, Imm12, Imm9, Shamt,
    output Rn, Rm, Rd, Rd2, forward_Da, forward_Db, load_use
  );

  modport slave (
    output instruction, alu_zero, cbz_zero, negative, overflow,
    input  Reg2Loc, ALU_Src, Imm2ALU, UncondBr, BrTaken,
    input  Shift2Reg, SetFlags, MemWren, Mem2Reg, RegWren, ALU_Op,
    input  Imm26, Imm19, Imm12, Imm9, Shamt,
    input  Rn, Rm, Rd, Rd2, forward_Da, forward_Db, load_use
  );

endinterface

// File: rtl/cpu_control_decode.sv
// ID-stage decoder: opcode -> control bundle carried down the pipe, plus the
// operand selects and branch classes consumed in ID itself.
module cpu_control_decode
  import cpu_pkg::*;
(
  input  logic [10:0] opcode_i,
  input  logic [3:0]  cond_i,
  input  logic [5:0]  shamt_i,
  output ctrl_t       ctrl_o,
  output logic        reg2loc_o,
  output logic        alu_src_o,
  output logic        imm2alu_o,
  output logic        is_b_o,
  output logic        is_cbz_o,
  output logic        is_blt_o
);

  always_comb begin
    // NOTE: every output is given a default before the case, so no path can leave one unassigned and infer a latch.
    ctrl_o         = CTRL_BUBBLE;
    ctrl_o.mem2reg = 1'b1;
    reg2loc_o      = 1'b1;
    alu_src_o      = 1'b1;
    imm2alu_o      = 1'b0;
    is_b_o         = 1'b0;
    is_cbz_o       = 1'b0;
    is_blt_o       = 1'b0;

    // Opcode fields have different widths; shorter ones are padded with wildcards.
    casez (opcode_i)
      {OP_ADDI, 1'b?}: begin
        ctrl_o.reg_wren = 1'b1;
        ctrl_o.alu_op   = ALU_ADD;
        alu_src_o       = 1'b0;
        imm2alu_o       = 1'b1;
      end
      OP_ADDS: begin
        ctrl_o.reg_wren  = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.set_flags = 1'b1;
      end
      OP_SUBS: begin
        ctrl_o.reg_wren  = 1'b1;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.set_flags = 1'b1;
      end
      OP_AND: begin
        ctrl_o.reg_wren = 1'b1;
        ctrl_o.alu_op   = ALU_AND;
      end
      OP_EOR: begin
        ctrl_o.reg_wren = 1'b1;
        ctrl_o.alu_op   = ALU_XOR;
      end
      OP_LSR: begin
        ctrl_o.reg_wren  = 1'b1;
        ctrl_o.shift2reg = 1'b1;
        ctrl_o.shamt     = shamt_i;
      end
      OP_LDUR: begin
        ctrl_o.reg_wren = 1'b1;
        ctrl_o.mem2reg  = 1'b0;
        ctrl_o.alu_op   = ALU_ADD;
        alu_src_o       = 1'b0;
      end
      OP_STUR: begin
        ctrl_o.mem_wren = 1'b1;
        ctrl_o.alu_op   = ALU_ADD;
        alu_src_o       = 1'b0;
        reg2loc_o       = 1'b0;
      end
      {OP_CBZ, 3'b???}: begin
        is_cbz_o  = 1'b1;
        reg2loc_o = 1'b0;
      end
      {OP_BCOND, 3'b???}: begin
        is_blt_o = (cond_i == COND_LT);
      end
      {OP_B, 5'b?????}: begin
        is_b_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cpu_control_pipeline.sv
// LEGv8 pipeline control: ID decode and branch resolution, EX/MEM/WB control
// registers, and the forwarding/load-use detection for the ID-stage operands.
module cpu_control_pipeline
  import cpu_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_control_pipeline_if.master bus
);

  localparam int            AW       = $clog2(NUM_REGS);
  localparam logic [AW-1:0] ZERO_IDX = AW'(ZERO_REG);

  ctrl_t         ex_d, ex_q;
  mem_ctrl_t     mem_d, mem_q;
  logic [AW-1:0] ex_rd_d, ex_rd_q, mem_rd_q, wb_rd_q;
  logic          wb_wren_q;

  logic          reg2loc, alu_src, imm2alu;
  logic          is_b, is_cbz, is_blt;
  logic [AW-1:0] src_a, src_b;
  logic          ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic          ex_is_load;
  logic          unused_alu_zero;

  cpu_control_decode u_decode (
    .opcode_i  (bus.instruction[31:21]),
    .cond_i    (bus.instruction[3:0]),
    .shamt_i   (bus.instruction[15:10]),
    .ctrl_o    (ex_d),
    .reg2loc_o (reg2loc),
    .alu_src_o (alu_src),
    .imm2alu_o (imm2alu),
    .is_b_o    (is_b),
    .is_cbz_o  (is_cbz),
    .is_blt_o  (is_blt)
  );

  // ID-stage fields and selects, straight from the instruction.
  assign bus.Rn       = bus.instruction[5 +: AW];
  assign bus.Rm       = bus.instruction[16 +: AW];
  assign bus.Rd       = bus.instruction[0 +: AW];
  assign bus.Imm26    = bus.instruction[25:0];
  assign bus.Imm19    = bus.instruction[23:5];
  assign bus.Imm12    = bus.instruction[21:10];
  assign bus.Imm9     = bus.instruction[20:12];
  assign bus.Reg2Loc  = reg2loc;
  assign bus.ALU_Src  = alu_src;
  assign bus.Imm2ALU  = imm2alu;
  assign bus.UncondBr = is_b;

  // Resolved in ID with one delay slot; N/V arrive already forwarded from EX.
  assign bus.BrTaken = is_b
                     | (is_cbz & bus.cbz_zero)
                     | (is_blt & (bus.negative ^ bus.overflow));

  // The Z flag is not used by any supported instruction.
  assign unused_alu_zero = bus.alu_zero;

  // Forwarding: compare the two ID sources against the EX and MEM writers.
  assign src_a     = bus.Rn;
  assign src_b     = reg2loc ? bus.Rm : bus.Rd;
  assign ex_hit_a  = ex_q.reg_wren  && (ex_rd_q  == src_a) && (src_a != ZERO_IDX);
  assign ex_hit_b  = ex_q.reg_wren  && (ex_rd_q  == src_b) && (src_b != ZERO_IDX);
  assign mem_hit_a = mem_q.reg_wren && (mem_rd_q == src_a) && (src_a != ZERO_IDX);
  assign mem_hit_b = mem_q.reg_wren && (mem_rd_q == src_b) && (src_b != ZERO_IDX);

  assign bus.forward_Da = FWD_EN ? fwd_sel(ex_hit_a, mem_hit_a) : FWD_REG;
  assign bus.forward_Db = FWD_EN ? fwd_sel(ex_hit_b, mem_hit_b) : FWD_REG;

  // LDUR is the only writer that takes its result from memory.
  assign ex_is_load   = ex_q.reg_wren & ~ex_q.mem2reg;
  assign bus.load_use = ex_is_load & (ex_hit_a | ex_hit_b);

  assign ex_rd_d = bus.instruction[0 +: AW];
  assign mem_d   = '{reg_wren: ex_q.reg_wren,
                     mem_wren: ex_q.mem_wren,
                     mem2reg:  ex_q.mem2reg};

  // Stage registers: no stall or flush, every stage advances each cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q      <= CTRL_BUBBLE;
      ex_rd_q   <= '0;
      mem_q     <= '0;
      mem_rd_q  <= '0;
      wb_wren_q <= 1'b0;
      wb_rd_q   <= '0;
    end else begin
      // NOTE: non-blocking updates let each stage capture its predecessor's pre-edge value.
      ex_q      <= ex_d;
      ex_rd_q   <= ex_rd_d;
      mem_q     <= mem_d;
      mem_rd_q  <= ex_rd_q;
      wb_wren_q <= mem_q.reg_wren;
      wb_rd_q   <= mem_rd_q;
    end
  end

  assign bus.ALU_Op    = ex_q.alu_op;
  assign bus.Shift2Reg = ex_q.shift2reg;
  assign bus.SetFlags  = ex_q.set_flags;
  assign bus.Shamt     = ex_q.shamt;
  assign bus.MemWren   = mem_q.mem_wren;
  assign bus.Mem2Reg   = mem_q.mem2reg;
  assign bus.RegWren   = wb_wren_q;
  assign bus.Rd2       = wb_rd_q;

endmodule

// File: tb/tb_cpu_control_pipeline.sv
// Directed program through the control pipeline; expectations are queued per
// cycle by the driver and checked by an independent monitor on the falling edge.
module tb_cpu_control_pipeline;

  localparam logic [10:0] ADDS  = 11'b10101011000;
  localparam logic [10:0] SUBS  = 11'b11101011000;
  localparam logic [10:0] LDUR  = 11'b11111000010;
  localparam logic [10:0] STUR  = 11'b11111000000;
  localparam logic [7:0]  CBZ   = 8'b10110100;
  localparam logic [7:0]  BCOND = 8'b01010100;
  localparam logic [31:0] NOP   = 32'hFFFF_FFFF;

  typedef enum {
    F_REG_WREN, F_RD2, F_MEM_WREN, F_MEM2REG, F_SET_FLAGS, F_ALU_OP,
    F_FWD_A, F_FWD_B, F_REG2LOC, F_ALU_SRC, F_BR_TAKEN, F_UNCOND,
    F_IMM19, F_IMM12, F_LOAD_USE
  } fld_e;

  typedef struct {
    int          cyc;
    fld_e        fld;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic   clk;
  logic   reset;
  int     checks   = 0;
  int     failures = 0;
  int     cur_cyc  = 0;
  exp_t   sb[$];

  cpu_control_pipeline_if #(.NUM_REGS(32)) bus ();

  cpu_control_pipeline #(
    .NUM_REGS (32),
    .ZERO_REG (31),
    .FWD_EN   (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] r_ins(input logic [10:0] op, input int rm, input int rn, input int rd);
    return {op, 5'(rm), 6'd0, 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] addi_ins(input int rd, input int rn, input int imm);
    return {10'b1001000100, 12'(imm), 5'(rn), 5'(rd)};
  endfunction

  function automatic logic [31:0] d_ins(input logic [10:0] op, input int rt, input int rn, input int imm);
    return {op, 9'(imm), 2'b00, 5'(rn), 5'(rt)};
  endfunction

  function automatic logic [31:0] cb_ins(input logic [7:0] op, input int imm, input int rt);
    return {op, 19'(imm), 5'(rt)};
  endfunction

  function automatic logic [31:0] b_ins(input int imm);
    return {6'b000101, 26'(imm)};
  endfunction

  function automatic logic [31:0] dut_field(input fld_e f);
    logic [31:0] v;
    v = '0;
    case (f)
      F_REG_WREN:  v = 32'(bus.RegWren);
      F_RD2:       v = 32'(bus.Rd2);
      F_MEM_WREN:  v = 32'(bus.MemWren);
      F_MEM2REG:   v = 32'(bus.Mem2Reg);
      F_SET_FLAGS: v = 32'(bus.SetFlags);
      F_ALU_OP:    v = 32'(bus.ALU_Op);
      F_FWD_A:     v = 32'(bus.forward_Da);
      F_FWD_B:     v = 32'(bus.forward_Db);
      F_REG2LOC:   v = 32'(bus.Reg2Loc);
      F_ALU_SRC:   v = 32'(bus.ALU_Src);
      F_BR_TAKEN:  v = 32'(bus.BrTaken);
      F_UNCOND:    v = 32'(bus.UncondBr);
      F_IMM19:     v = 32'(bus.Imm19);
      F_IMM12:     v = 32'(bus.Imm12);
      F_LOAD_USE:  v = 32'(bus.load_use);
      default:     v = 'x;
    endcase
    return v;
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic step(input logic [31:0] ins, input logic rst_v,
                      input logic cz, input logic ng, input logic ov);
    @(posedge clk);
    #1;
    reset           = rst_v;
    bus.instruction = ins;
    bus.cbz_zero    = cz;
    bus.negative    = ng;
    bus.overflow    = ov;
    bus.alu_zero    = 1'b0;
    cur_cyc++;
  endtask

  task automatic exp_push(input fld_e f, input logic [31:0] v, input string name);
    exp_t e;
    e.cyc  = cur_cyc;
    e.fld  = f;
    e.val  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: pops every expectation belonging to the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc <= cur_cyc) begin
        e   = sb.pop_front();
        got = dut_field(e.fld);
        checks++;
        if (e.cyc != cur_cyc) begin
          failures++;
          $display("FAIL %s stale: queued for cycle %0d, seen at cycle %0d", e.name, e.cyc, cur_cyc);
        end else if (got !== e.val) begin
          failures++;
          $display("FAIL %s cycle=%0d got=%0h want=%0h", e.name, cur_cyc, got, e.val);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    reset           = 1'b0;
    bus.instruction = r_ins(ADDS, 3, 2, 1);
    bus.cbz_zero    = 1'b0;
    bus.negative    = 1'b0;
    bus.overflow    = 1'b0;
    bus.alu_zero    = 1'b0;

    // Reset held with ADDS X1,X2,X3 in ID.
    step(r_ins(ADDS, 3, 2, 1), 1'b0, 1'b0, 1'b0, 1'b0);
    step(r_ins(ADDS, 3, 2, 1), 1'b0, 1'b0, 1'b0, 1'b0);
    exp_push(F_REG_WREN,  0, "rst_regwren");
    exp_push(F_RD2,       0, "rst_rd2");
    exp_push(F_MEM_WREN,  0, "rst_memwren");
    exp_push(F_SET_FLAGS, 0, "rst_setflags");
    exp_push(F_MEM2REG,   0, "rst_mem2reg");

    // Release; ADDS X1 reaches WB after the third edge.
    step(r_ins(ADDS, 3, 2, 1), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_FWD_A,   0, "fwd_a_empty_pipe");
    exp_push(F_REG2LOC, 1, "reg2loc_rtype");
    exp_push(F_ALU_SRC, 1, "alu_src_rtype");
    step(addi_ins(1, 31, 5), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_IMM12,   5, "imm12_addi");
    exp_push(F_ALU_SRC, 0, "alu_src_addi");
    step(r_ins(ADDS, 1, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_FWD_A,    2, "fwd_a_ex_over_mem");
    exp_push(F_FWD_B,    2, "fwd_b_ex_over_mem");
    exp_push(F_REG_WREN, 0, "regwren_before_3rd_edge");
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_REG_WREN,  1, "regwren_3rd_edge");
    exp_push(F_RD2,       1, "rd2_3rd_edge");
    exp_push(F_SET_FLAGS, 1, "setflags_adds_ex");
    exp_push(F_ALU_OP,    3'b010, "aluop_adds");

    // ADDI X1; bubble; STUR X1 -> Db forwarded from MEM.
    step(addi_ins(1, 31, 7), 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_RD2, 2, "rd2_adds_x2");
    step(d_ins(STUR, 1, 4, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_FWD_B,   1, "fwd_b_stur_mem");
    exp_push(F_REG2LOC, 0, "reg2loc_stur");
    exp_push(F_FWD_A,   0, "fwd_a_stur_base");

    // Write to X31 then read X31: never forwarded.
    step(addi_ins(31, 2, 1), 1'b1, 1'b0, 1'b0, 1'b0);
    step(r_ins(ADDS, 31, 31, 5), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_FWD_A,    0, "fwd_a_xzr");
    exp_push(F_FWD_B,    0, "fwd_b_xzr");
    exp_push(F_MEM_WREN, 1, "memwren_stur_mem");

    // CBZ X5 taken / not taken.
    step(cb_ins(CBZ, 'h12345, 5), 1'b1, 1'b1, 1'b0, 1'b0);
    exp_push(F_BR_TAKEN, 1, "cbz_taken");
    exp_push(F_UNCOND,   0, "cbz_uncond");
    exp_push(F_IMM19,    19'h12345, "cbz_imm19");
    exp_push(F_FWD_B,    2, "fwd_b_cbz_ex");
    step(cb_ins(CBZ, 'h12345, 5), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_BR_TAKEN, 0, "cbz_not_taken");
    exp_push(F_FWD_B,    1, "fwd_b_cbz_mem");

    // B.LT behind SUBS.
    step(r_ins(SUBS, 8, 7, 6), 1'b1, 1'b0, 1'b0, 1'b0);
    step(cb_ins(BCOND, 5, 'hB), 1'b1, 1'b0, 1'b1, 1'b0);
    exp_push(F_BR_TAKEN,  1, "blt_taken");
    exp_push(F_SET_FLAGS, 1, "setflags_subs_ex");
    exp_push(F_ALU_OP,    3'b011, "aluop_subs");
    step(cb_ins(BCOND, 5, 'hB), 1'b1, 1'b0, 1'b1, 1'b1);
    exp_push(F_BR_TAKEN, 0, "blt_n_eq_v");
    step(cb_ins(BCOND, 5, 'h0), 1'b1, 1'b0, 1'b1, 1'b0);
    exp_push(F_BR_TAKEN, 0, "bcond_eq_unsupported");
    step(b_ins('h123456), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_BR_TAKEN, 1, "b_taken");
    exp_push(F_UNCOND,   1, "b_uncond");

    // Load-use: LDUR X3 in EX, ADDS X4,X3,X3 in ID.
    step(d_ins(LDUR, 3, 9, 8), 1'b1, 1'b0, 1'b0, 1'b0);
    step(r_ins(ADDS, 3, 3, 4), 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_LOAD_USE, 1, "load_use_hit");
    exp_push(F_FWD_A,    2, "fwd_a_load");

    // Unrecognised opcode flows through as a bubble.
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_MEM2REG,  0, "mem2reg_ldur");
    exp_push(F_LOAD_USE, 0, "load_use_clear");
    exp_push(F_BR_TAKEN, 0, "bubble_brtaken");
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_SET_FLAGS, 0, "bubble_setflags_ex");
    exp_push(F_REG_WREN,  1, "ldur_wb_wren");
    exp_push(F_RD2,       3, "ldur_wb_rd2");
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_MEM_WREN, 0, "bubble_memwren");
    exp_push(F_MEM2REG,  1, "bubble_mem2reg");
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    exp_push(F_REG_WREN, 0, "bubble_regwren_wb");

    // Mid-program reset drops in-flight STUR (MEM) and ADDI X10 (WB).
    step(addi_ins(10, 31, 1), 1'b1, 1'b0, 1'b0, 1'b0);
    step(d_ins(STUR, 1, 2, 0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    exp_push(F_MEM_WREN, 0, "midrst_memwren");
    exp_push(F_REG_WREN, 0, "midrst_regwren");
    exp_push(F_RD2,      0, "midrst_rd2");
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);
    step(NOP, 1'b1, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d expectations left unchecked, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
